dma_engine: RTL and testbench

- Responder side of the core's DMA command interface (dma_en/funct3/imm/rs1/rs2, dma_busy).
- Accepts one command, then moves words through a shared data-memory port using a req/gnt handshake. Writes are either a buffered copy or a constant fill.
- Holds dma_busy_o high for the whole transfer; the core stalls while it is high.
- Sits beside the core on the dmem arbiter as a second master.

---
 rtl/dma_engine.sv | 146 ++++++++++++++
 tb/tb_dma_engine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_engine.sv
// DMA responder: accepts one COPY/FILL command, moves words over a req/gnt memory port.
// COPY reads a chunk of up to BURST words into a local buffer, then writes it back out.
module dma_engine #(
  parameter int XLEN  = 32,
  parameter int BURST = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dma_en_i,
  input  logic [2:0]      dma_funct3_i,
  input  logic [11:0]     dma_imm_i,
  input  logic [XLEN-1:0] dma_rs1_i,
  input  logic [XLEN-1:0] dma_rs2_i,
  output logic            dma_busy_o,
  output logic            dma_done_o,
  output logic            dma_err_o,
  output logic            req_o,
  input  logic            gnt_i,
  output logic [XLEN-1:0] addr_o,
  input  logic [XLEN-1:0] rd_data_i,
  output logic [XLEN-1:0] wr_data_o,
  output logic [3:0]      size_o,
  output logic            read_o,
  output logic            write_o
);
  localparam int IW = $clog2(BURST);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

  state_t            state_q;
  logic              copy_q;
  logic [11:0]       rem_q;
  logic [11:0]       rem_d;
  logic [CW-1:0]     chunk_q;
  logic [CW-1:0]     rd_cnt_q;
  logic [CW-1:0]     wr_cnt_q;
  logic [XLEN-1:0]   src_q;
  logic [XLEN-1:0]   dst_q;
  logic [XLEN-1:0]   fill_q;
  logic              cap_q;
  logic [IW-1:0]     cap_idx_q;
  logic              done_q;
  logic              err_q;
  logic [XLEN-1:0]   buf_q [BURST];

  function automatic logic [CW-1:0] chunk_of(input logic [11:0] r);
    if (r >= 12'(BURST)) return CW'(BURST);
    else                 return CW'(r);
  endfunction

  assign rem_d = rem_q - 12'(chunk_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      copy_q    <= 1'b0;
      rem_q     <= '0;
      chunk_q   <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      fill_q    <= '0;
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cap_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dma_en_i) begin
            if (dma_funct3_i == 3'b000 || dma_funct3_i == 3'b001) begin
              if (dma_imm_i == 12'd0) begin
                done_q <= 1'b1;
              end else begin
                copy_q   <= (dma_funct3_i == 3'b000);
                rem_q    <= dma_imm_i;
                chunk_q  <= chunk_of(dma_imm_i);
                src_q    <= {dma_rs1_i[XLEN-1:2], 2'b00};
                dst_q    <= {dma_rs2_i[XLEN-1:2], 2'b00};
                fill_q   <= dma_rs1_i;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
                state_q  <= (dma_funct3_i == 3'b000) ? READ : WRITE;
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (gnt_i) begin
            src_q     <= src_q + XLEN'(4);
            rd_cnt_q  <= rd_cnt_q + CW'(1);
            // data for this grant arrives next cycle; remember where it goes
            cap_q     <= 1'b1;
            cap_idx_q <= rd_cnt_q[IW-1:0];
            if (rd_cnt_q == chunk_q - CW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          wr_cnt_q <= '0;
          state_q  <= WRITE;
        end
        WRITE: begin
          if (gnt_i) begin
            dst_q    <= dst_q + XLEN'(4);
            wr_cnt_q <= wr_cnt_q + CW'(1);
            if (wr_cnt_q == chunk_q - CW'(1)) begin
              rem_q    <= rem_d;
              chunk_q  <= chunk_of(rem_d);
              rd_cnt_q <= '0;
              wr_cnt_q <= '0;
              if (rem_d == 12'd0) begin
                state_q <= IDLE;
                done_q  <= 1'b1;
              end else if (copy_q) begin
                state_q <= READ;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (cap_q) buf_q[cap_idx_q] <= rd_data_i;
  end

  assign dma_busy_o = (state_q != IDLE);
  assign dma_done_o = done_q;
  assign dma_err_o  = err_q;
  assign read_o     = (state_q == READ);
  assign write_o    = (state_q == WRITE);
  assign req_o      = read_o | write_o;
  assign size_o     = req_o ? 4'b1111 : 4'b0000;
  assign addr_o     = read_o ? src_q : (write_o ? dst_q : '0);
  assign wr_data_o  = write_o ? (copy_q ? buf_q[wr_cnt_q[IW-1:0]] : fill_q) : '0;

endmodule

// File: tb/tb_dma_engine.sv
// Directed bench for dma_engine: word memory model on the req/gnt port plus per-step checks.
module tb_dma_engine;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  f3 = '0;
  logic [11:0] imm = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        gnt = 1'b0;
  logic [31:0] rd_data = '0;
  logic        busy, done, err, req, rd, wr;
  logic [31:0] addr, wdata;
  logic [3:0]  size;

  dma_engine #(.XLEN(32), .BURST(4)) dut (
    .clk_i(clk), .rst_i(rst), .dma_en_i(en), .dma_funct3_i(f3), .dma_imm_i(imm),
    .dma_rs1_i(rs1), .dma_rs2_i(rs2), .dma_busy_o(busy), .dma_done_o(done),
    .dma_err_o(err), .req_o(req), .gnt_i(gnt), .addr_o(addr), .rd_data_i(rd_data),
    .wr_data_o(wdata), .size_o(size), .read_o(rd), .write_o(wr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [0:1023];
  int busy_cnt = 0, done_cnt = 0, err_cnt = 0, req_cnt = 0, rd_cnt = 0, viol_cnt = 0;
  logic [32:0] log_a[$];
  logic [31:0] log_d[$];
  logic [32:0] ea[$];
  logic [31:0] ed[$];
  bit stall_mode = 0;
  int wait_n = 0;
  bit pend_rd = 0;
  logic [31:0] pend_addr = '0;
  bit prev_stalled = 0;
  logic [31:0] prev_addr, prev_wd;
  logic prev_rd, prev_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    busy_cnt = 0; done_cnt = 0; err_cnt = 0; req_cnt = 0; rd_cnt = 0;
    log_a.delete(); log_d.delete(); ea.delete(); ed.delete();
  endtask

  task automatic issue(input logic [2:0] f, input logic [11:0] n,
                       input logic [31:0] a, input logic [31:0] b);
    clr();
    @(negedge clk);
    en = 1'b1; f3 = f; imm = n; rs1 = a; rs2 = b;
    @(posedge clk);
    #2 en = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done_cnt == 0 && k < limit) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic exp_rd(input logic [31:0] a);
    ea.push_back({1'b0, a}); ed.push_back(32'h0);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    ea.push_back({1'b1, a}); ed.push_back(d);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_naccess"}, 32'(log_a.size()), 32'(ea.size()));
    for (int i = 0; i < ea.size() && i < log_a.size(); i++) begin
      check($sformatf("%s_kind%0d", tag, i), 32'(log_a[i][32]), 32'(ea[i][32]));
      check($sformatf("%s_addr%0d", tag, i), log_a[i][31:0], ea[i][31:0]);
      check($sformatf("%s_data%0d", tag, i), log_d[i], ed[i]);
    end
  endtask

  // bus monitor and memory write side, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (req)  req_cnt++;
    if (rd)   rd_cnt++;
    if (size !== (req ? 4'hF : 4'h0)) viol_cnt++;
    if (req && addr[1:0] != 2'b00) viol_cnt++;
    if (rd && wr) viol_cnt++;
    if (prev_stalled && (!req || addr !== prev_addr || rd !== prev_rd ||
                         wr !== prev_wr || wdata !== prev_wd)) viol_cnt++;
    prev_stalled = req && !gnt;
    prev_addr = addr; prev_rd = rd; prev_wr = wr; prev_wd = wdata;
    if (req && gnt) begin
      log_a.push_back({wr, addr});
      log_d.push_back(wr ? wdata : 32'h0);
      if (wr) mem[addr[11:2]] = wdata;
      else begin pend_rd = 1; pend_addr = addr; end
    end
  end

  // read data return and grant generation, just after each rising edge
  initial forever begin
    @(posedge clk);
    #1;
    if (pend_rd) rd_data = mem[pend_addr[11:2]];
    pend_rd = 0;
    if (!stall_mode) gnt = 1'b1;
    else if (req) begin
      if (wait_n < 3) begin gnt = 1'b0; wait_n++; end
      else begin gnt = 1'b1; wait_n = 0; end
    end else gnt = 1'b0;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, k;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_flags", {26'h0, done, err, req, rd, wr, 1'b0}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_size", 32'(size), 32'h0);
    rst = 1'b0;

    // COPY len=1 cycle-exact timing
    mem[64] = 32'h1111_1111;
    issue(3'b000, 12'd1, 32'h100, 32'h180);
    @(negedge clk);
    check("t1_c1_busy", 32'(busy), 32'h1);
    check("t1_c1_read", {rd, wr}, 32'h2);
    check("t1_c1_addr", addr, 32'h100);
    @(negedge clk);
    check("t1_c2_drain", {busy, req}, 32'h2);
    @(negedge clk);
    check("t1_c3_write", {busy, rd, wr}, 32'h5);
    check("t1_c3_addr", addr, 32'h180);
    check("t1_c3_data", wdata, 32'h1111_1111);
    @(negedge clk);
    check("t1_c4_done", {busy, done}, 32'h1);
    @(negedge clk);
    check("t1_done_pulse", {busy, done}, 32'h0);
    check("t1_mem", mem[96], 32'h1111_1111);

    // COPY len=3, unaligned rs1 low bits ignored
    mem[64] = 32'hAAAA_0001; mem[65] = 32'hAAAA_0002; mem[66] = 32'hAAAA_0003;
    issue(3'b000, 12'd3, 32'h103, 32'h202);
    wait_done(40);
    exp_rd(32'h100); exp_rd(32'h104); exp_rd(32'h108);
    exp_wr(32'h200, 32'hAAAA_0001); exp_wr(32'h204, 32'hAAAA_0002); exp_wr(32'h208, 32'hAAAA_0003);
    check_log("c3");
    check("c3_busy", 32'(busy_cnt), 32'd7);
    check("c3_done", 32'(done_cnt), 32'd1);

    // COPY len=6 splits into chunks of 4 and 2
    for (int i = 0; i < 6; i++) mem[320 + i] = 32'hC0DE_0000 + 32'(i);
    issue(3'b000, 12'd6, 32'h500, 32'h200);
    wait_done(60);
    for (int i = 0; i < 4; i++) exp_rd(32'h500 + 32'(4 * i));
    for (int i = 0; i < 4; i++) exp_wr(32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    for (int i = 4; i < 6; i++) exp_rd(32'h500 + 32'(4 * i));
    for (int i = 4; i < 6; i++) exp_wr(32'h200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
    check_log("c6");
    check("c6_busy", 32'(busy_cnt), 32'd14);
    check("c6_mem_last", mem[133], 32'hC0DE_0005);

    // FILL len=5
    issue(3'b001, 12'd5, 32'hDEAD_BEEF, 32'h300);
    wait_done(40);
    for (int i = 0; i < 5; i++) exp_wr(32'h300 + 32'(4 * i), 32'hDEAD_BEEF);
    check_log("f5");
    check("f5_reads", 32'(rd_cnt), 32'd0);
    check("f5_busy", 32'(busy_cnt), 32'd5);
    check("f5_done", 32'(done_cnt), 32'd1);

    // COPY len=2 with three stall cycles per access
    mem[448] = 32'h5555_0000; mem[449] = 32'h5555_0001;
    stall_mode = 1; wait_n = 0;
    issue(3'b000, 12'd2, 32'h700, 32'h800);
    wait_done(100);
    exp_rd(32'h700); exp_rd(32'h704);
    exp_wr(32'h800, 32'h5555_0000); exp_wr(32'h804, 32'h5555_0001);
    check_log("st");
    check("st_busy", 32'(busy_cnt), 32'd17);
    check("st_mem", mem[513], 32'h5555_0001);
    stall_mode = 0;

    // reserved funct3
    issue(3'b111, 12'd5, 32'h100, 32'h200);
    @(negedge clk);
    check("err_pulse", {busy, err, done}, 32'h2);
    repeat (3) @(negedge clk);
    check("err_cnt", 32'(err_cnt), 32'd1);
    check("err_noreq", 32'(req_cnt + busy_cnt + done_cnt), 32'd0);

    // zero length
    issue(3'b000, 12'd0, 32'h100, 32'h200);
    @(negedge clk);
    check("len0_pulse", {busy, err, done}, 32'h1);
    repeat (3) @(negedge clk);
    check("len0_cnt", 32'(done_cnt), 32'd1);
    check("len0_noreq", 32'(req_cnt + busy_cnt + err_cnt), 32'd0);

    // reset during the second write of a len=4 COPY
    for (int i = 0; i < 4; i++) mem[64 + i] = 32'hBBBB_0000 + 32'(i);
    issue(3'b000, 12'd4, 32'h100, 32'h900);
    w = 0; k = 0;
    while (w < 2 && k < 50) begin
      @(negedge clk);
      k++;
      if (wr) w++;
    end
    check("rst_reach_write2", 32'(w), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_flags", {26'h0, busy, done, err, req, rd, wr}, 32'h0);
    check("mid_rst_addr", addr, 32'h0);
    check("mid_rst_size", 32'(size), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_rst_nodone", 32'(done_cnt), 32'd0);
    check("mid_rst_naccess", 32'(log_a.size()), 32'd6);
    check("mid_rst_mem3", mem[578], 32'h0);

    // engine usable after abort
    issue(3'b001, 12'd1, 32'h1234_5678, 32'hA00);
    wait_done(20);
    check("post_rst_mem", mem[640], 32'h1234_5678);
    check("post_rst_done", 32'(done_cnt), 32'd1);
    check("post_rst_busy", 32'(busy_cnt), 32'd1);

    check("bus_protocol_violations", 32'(viol_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
